// File: rtl/count_monitor.sv
// Checker stage behind a free-running counter: detects wraps, sequence breaks and
// counter resets, queues them as events and hands them off over valid/ready.
module count_monitor #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_rst,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [WIDTH-1:0] evt_value,
    output logic [LAP_W-1:0] evt_lap,
    output logic [LAP_W-1:0] lap_count,
    output logic             overflow
);
    // Handshake: the head entry transfers at a rising edge where evt_valid and
    // evt_ready are both high; evt_* hold steady while evt_valid=1, evt_ready=0.

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + WIDTH + LAP_W;

    localparam logic [1:0] EVT_WRAP = 2'b01;
    localparam logic [1:0] EVT_SKIP = 2'b10;
    localparam logic [1:0] EVT_RST  = 2'b11;

    typedef enum logic {
        S_SYNC  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];

    logic [WIDTH-1:0] exp_cnt;
    logic [LAP_W-1:0] lap_inc;
    logic             ev_push;
    logic [1:0]       ev_type;
    logic [WIDTH-1:0] ev_value;
    logic [LAP_W-1:0] ev_lap;
    logic             fifo_empty, fifo_full, pop, accept;
    logic [EW-1:0]    head;

    assign exp_cnt = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign lap_inc = lap_q + {{(LAP_W-1){1'b0}}, 1'b1};

    // Event detection: at most one event per sampled edge.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        lap_d    = lap_q;
        ev_push  = 1'b0;
        ev_type  = 2'b00;
        ev_value = count_in;
        ev_lap   = lap_q;
        case (state_q)
            S_SYNC: begin
                if (!count_rst) begin
                    prev_d  = count_in;
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (count_rst) begin
                    ev_push = 1'b1;
                    ev_type = EVT_RST;
                    ev_lap  = '0;
                    lap_d   = '0;
                    state_d = S_SYNC;
                end else if (count_in == exp_cnt) begin
                    prev_d = count_in;
                    if (exp_cnt == '0) begin
                        lap_d   = lap_inc;
                        ev_push = 1'b1;
                        ev_type = EVT_WRAP;
                        ev_lap  = lap_inc;
                    end
                end else begin
                    prev_d  = count_in;
                    ev_push = 1'b1;
                    ev_type = EVT_SKIP;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // Extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = evt_valid && evt_ready;
    assign accept     = ev_push && (!fifo_full || pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q;
        if (accept) begin
            mem_d[wr_q[AW-1:0]] = {ev_type, ev_value, ev_lap};
            wr_d                = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
        if (ev_push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_SYNC;
            prev_q  <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end

    // Idle outputs read as zero so a stale popped entry never shows.
    assign head      = mem_q[rd_q[AW-1:0]];
    assign evt_valid = !fifo_empty;
    assign evt_type  = evt_valid ? head[EW-1 -: 2] : 2'b00;
    assign evt_value = evt_valid ? head[LAP_W +: WIDTH] : '0;
    assign evt_lap   = evt_valid ? head[LAP_W-1:0] : '0;
    assign lap_count = lap_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: vector table plus multi-cycle FIFO and reset sequences.
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       count_rst;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [3:0] evt_value;
  logic [7:0] evt_lap;
  logic [7:0] lap_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [3:0] cin;
    logic       rdy;
    logic       v;
    logic [1:0] t;
    logic [3:0] val;
    logic [7:0] lap;
    logic [7:0] lc;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  count_monitor #(.WIDTH(4), .DEPTH(4), .LAP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .count_rst (count_rst),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_value (evt_value),
    .evt_lap   (evt_lap),
    .lap_count (lap_count),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset     = 1'b1;
    count_rst = 1'b0;
    count_in  = 4'd0;
    evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // driver: apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic rst, input logic [3:0] c, input logic rdy);
    count_rst = rst;
    count_in  = c;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] cin, input logic rdy,
                     input logic v, input logic [1:0] t, input logic [3:0] val,
                     input logic [7:0] lap, input logic [7:0] lc, input logic ov);
    vec_t e;
    e.rst = rst; e.cin = cin; e.rdy = rdy;
    e.v = v; e.t = t; e.val = val; e.lap = lap; e.lc = lc; e.ov = ov;
    vecs.push_back(e);
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [1:0] t,
                            input logic [3:0] val, input logic [7:0] lap,
                            input logic [7:0] lc, input logic ov);
    check({tag, ".valid"}, evt_valid, v);
    check({tag, ".type"}, evt_type, t);
    check({tag, ".value"}, evt_value, val);
    check({tag, ".lap"}, evt_lap, lap);
    check({tag, ".lap_count"}, lap_count, lc);
    check({tag, ".overflow"}, overflow, ov);
  endtask

  task automatic count_lap(input logic rdy);
    for (int c = 1; c < 16; c++) step(1'b0, c[3:0], rdy);
    step(1'b0, 4'd0, rdy);
  endtask

  initial begin
    // vector table: sync, one full lap, skip, counter reset, hold
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 16; c++) add(0, c[3:0], 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 2'b01, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 2, 1, 0, 0, 0, 0, 1, 0);
    add(0, 3, 1, 0, 0, 0, 0, 1, 0);
    add(0, 4, 1, 0, 0, 0, 0, 1, 0);
    add(0, 5, 1, 0, 0, 0, 0, 1, 0);
    add(0, 9, 1, 1, 2'b10, 9, 1, 1, 0);
    add(0, 10, 1, 0, 0, 0, 0, 1, 0);
    add(1, 7, 1, 1, 2'b11, 7, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 2'b10, 1, 0, 0, 0);
    add(0, 2, 1, 0, 0, 0, 0, 0, 0);

    do_reset();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].cin, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].t, vecs[i].val,
                 vecs[i].lap, vecs[i].lc, vecs[i].ov);
    end

    // five wraps with consumer stalled: fifth is dropped
    do_reset();
    step(1'b0, 4'd0, 1'b0);
    for (int w = 1; w <= 5; w++) begin
      count_lap(1'b0);
      if (w <= 4) exp_q.push_back(w[7:0]);
      if (w == 4) check("ovf.before_drop", overflow, 0);
    end
    check_outs("ovf.after5", 1, 2'b01, 0, 1, 5, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf.drain_valid", evt_valid, 1);
      check("ovf.drain_lap", evt_lap, exp_q.pop_front());
      step(1'b0, k[3:0], 1'b1);
    end
    check("ovf.empty", evt_valid, 0);
    check("ovf.sticky", overflow, 1);

    // full FIFO, wrap coincides with a pop: accepted, no overflow
    do_reset();
    step(1'b0, 4'd0, 1'b0);
    for (int w = 1; w <= 4; w++) begin
      count_lap(1'b0);
      exp_q.push_back(w[7:0]);
    end
    check("full.ovf", overflow, 0);
    for (int c = 1; c < 16; c++) step(1'b0, c[3:0], 1'b0);
    check("full.head_lap", evt_lap, exp_q.pop_front());
    step(1'b0, 4'd0, 1'b1);
    exp_q.push_back(8'd5);
    check("full.pop_push_ovf", overflow, 0);
    check("full.lap_count", lap_count, 5);
    for (int k = 1; k <= 4; k++) begin
      check("full.drain_valid", evt_valid, 1);
      check("full.drain_type", evt_type, 1);
      check("full.drain_lap", evt_lap, exp_q.pop_front());
      step(1'b0, k[3:0], 1'b1);
    end
    check("full.empty", evt_valid, 0);
    check("full.ovf_end", overflow, 0);

    // async reset between edges with an event pending
    step(1'b0, 4'd9, 1'b0);
    check("async.pending", evt_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async.now", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1'b1, 4'd7, 1'b1);
    check("async.rst_hold1", evt_valid, 0);
    step(1'b1, 4'd7, 1'b1);
    check("async.rst_hold2", evt_valid, 0);
    step(1'b0, 4'd5, 1'b1);
    check("async.sync_sample", evt_valid, 0);
    step(1'b0, 4'd9, 1'b1);
    check_outs("async.first_skip", 1, 2'b10, 9, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
